// File: rtl/rx_bit_timer.sv
// Receive bit-timing generator: recovers the bit phase from an oversampled line,
// resyncs on every data edge and issues sample/shift/byte strobes plus a no-edge timeout.
module rx_bit_timer #(
   parameter int OVS          = 8,
   parameter int SAMPLE_PHASE = 3,
   parameter int BYTE_BITS    = 8,
   parameter int MAX_RUN      = 7,
   localparam int PW = (OVS > 1) ? $clog2(OVS) : 1,
   localparam int CW = $clog2(BYTE_BITS + 1),
   localparam int RW = $clog2(MAX_RUN + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          d_edge,
   input  logic          rcving,
   input  logic          reset,
   input  logic          skip_bit,
   output logic          sample,
   output logic          shift_enable,
   output logic          byte_received,
   output logic [CW-1:0] bit_count,
   output logic          timeout_err
);

   localparam logic [PW-1:0] PH_LAST   = PW'(OVS - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
   localparam logic [CW-1:0] BC_FULL   = CW'(BYTE_BITS);
   localparam logic [CW-1:0] BC_LAST   = CW'(BYTE_BITS - 1);
   localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RUN);

   logic [PW-1:0] ph;
   logic [RW-1:0] run;
   logic [RW-1:0] run_nxt;
   logic          clr;

   assign clr    = reset | ~rcving;
   assign sample = rcving & ~reset & (ph == PH_SAMPLE);

   // an edge coincident with a sample wins, so a steady edge train never times out
   always_comb begin
      run_nxt = run;
      if (d_edge)
         run_nxt = '0;
      else if (sample && (run != RUN_MAX))
         run_nxt = run + RW'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ph            <= '0;
         run           <= '0;
         bit_count     <= '0;
         shift_enable  <= 1'b0;
         byte_received <= 1'b0;
         timeout_err   <= 1'b0;
      end else if (clr) begin
         ph            <= '0;
         run           <= '0;
         bit_count     <= '0;
         shift_enable  <= 1'b0;
         byte_received <= 1'b0;
         if (reset)
            timeout_err <= 1'b0;
      end else begin
         if (d_edge || (ph == PH_LAST))
            ph <= '0;
         else
            ph <= ph + PW'(1);

         run          <= run_nxt;
         timeout_err  <= timeout_err | (run_nxt == RUN_MAX);
         shift_enable <= sample & ~skip_bit;

         // bit_count shows BYTE_BITS for the byte_received cycle, then restarts
         byte_received <= shift_enable & (bit_count == BC_LAST);
         if (bit_count == BC_FULL)
            bit_count <= shift_enable ? CW'(1) : '0;
         else if (shift_enable)
            bit_count <= bit_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: directed scenarios plus random line activity, checked
// every cycle against an age/modulo based reference model.
module tb_rx_bit_timer;

   localparam int OVS = 8;
   localparam int SP  = 3;
   localparam int BB  = 8;
   localparam int MR  = 7;
   localparam int CW  = $clog2(BB + 1);

   logic          clk = 1'b0;
   logic          n_rst;
   logic          d_edge, rcving, reset, skip_bit;
   logic          sample, shift_enable, byte_received, timeout_err;
   logic [CW-1:0] bit_count;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int m_age;     // cycles since last resync; line phase is m_age % OVS
   int m_nbits;   // counted bits shown on bit_count
   int m_run;     // samples since last edge (unbounded)
   bit m_shift, m_byte, m_err;

   rx_bit_timer #(.OVS(OVS), .SAMPLE_PHASE(SP), .BYTE_BITS(BB), .MAX_RUN(MR)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .d_edge       (d_edge),
      .rcving       (rcving),
      .reset        (reset),
      .skip_bit     (skip_bit),
      .sample       (sample),
      .shift_enable (shift_enable),
      .byte_received(byte_received),
      .bit_count    (bit_count),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   function automatic bit exp_sample();
      return rcving && !reset && n_rst && ((m_age % OVS) == SP);
   endfunction

   task automatic model_clear(input bit clr_err);
      m_age = 0; m_nbits = 0; m_run = 0; m_shift = 0; m_byte = 0;
      if (clr_err) m_err = 0;
   endtask

   task automatic check();
      bit            es;
      logic [CW-1:0] ebc;
      es  = exp_sample();
      ebc = m_nbits[CW-1:0];
      vectors++;
      assert (sample === es) else begin
         miscompares++;
         $error("FAIL sample t=%0t got %b expected %b", $time, sample, es);
      end
      vectors++;
      assert (shift_enable === m_shift) else begin
         miscompares++;
         $error("FAIL shift_enable t=%0t got %b expected %b", $time, shift_enable, m_shift);
      end
      vectors++;
      assert (byte_received === m_byte) else begin
         miscompares++;
         $error("FAIL byte_received t=%0t got %b expected %b", $time, byte_received, m_byte);
      end
      vectors++;
      assert (bit_count === ebc) else begin
         miscompares++;
         $error("FAIL bit_count t=%0t got %0d expected %0d", $time, bit_count, ebc);
      end
      vectors++;
      assert (timeout_err === m_err) else begin
         miscompares++;
         $error("FAIL timeout_err t=%0t got %b expected %b", $time, timeout_err, m_err);
      end
   endtask

   // advance the model across one rising edge using the inputs now applied
   task automatic model_edge();
      bit s;
      bit sh;
      int base;
      s  = exp_sample();
      sh = m_shift;
      if (reset) begin
         model_clear(1'b1);
      end else if (!rcving) begin
         model_clear(1'b0);
      end else begin
         base    = m_nbits % BB;
         m_byte  = sh && (base + 1 == BB);
         m_nbits = sh ? base + 1 : base;
         m_shift = s && !skip_bit;
         if (d_edge)  m_run = 0;
         else if (s)  m_run = m_run + 1;
         if (m_run >= MR) m_err = 1;
         m_age = d_edge ? 0 : m_age + 1;
      end
   endtask

   task automatic cycle(input bit de, input bit rc, input bit rs, input bit sk);
      d_edge = de; rcving = rc; reset = rs; skip_bit = sk;
      @(negedge clk);
      check();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input int n, input bit sk);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, sk);
   endtask

   task automatic pulse_nrst();
      d_edge = 0; skip_bit = 0;
      #2 n_rst = 1'b0;
      model_clear(1'b1);
      #1 check();
      @(negedge clk);
      check();
      #1 n_rst = 1'b1;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  cnt, drop;
      bit  de, rc, rs, sk;

      n_rst = 1'b0; d_edge = 0; rcving = 0; reset = 0; skip_bit = 0;
      model_clear(1'b1);
      @(negedge clk);
      check();
      n_rst = 1'b1;
      model_edge();
      @(posedge clk);
      #1;

      // one edge then free-running: samples every OVS clocks
      cycle(1, 1, 0, 0);
      quiet(26, 0);

      // a full byte with edges every bit period
      cycle(0, 0, 0, 0);
      for (int b = 0; b < 10; b++) begin
         cycle(1, 1, 0, 0);
         quiet(7, 0);
      end

      // late edge at phase 2 pushes the next sample out
      cycle(1, 1, 0, 0);
      quiet(9, 0);
      cycle(1, 1, 0, 0);
      quiet(10, 0);

      // stuffed 4th bit of a byte
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      for (int b = 0; b < 11; b++) begin
         cycle(1, 1, 0, b == 3);
         quiet(7, b == 3);
      end

      // no edges long enough to time out; sticky through rcving low
      cycle(0, 1, 1, 0);
      cycle(1, 1, 0, 0);
      quiet(64, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      quiet(10, 0);
      cycle(0, 1, 1, 0);
      quiet(3, 0);

      // rcving dropped after 5 bits
      for (int b = 0; b < 5; b++) begin
         cycle(1, 1, 0, 0);
         quiet(7, 0);
      end
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);

      // async reset mid-byte
      for (int b = 0; b < 3; b++) begin
         cycle(1, 1, 0, 0);
         quiet(7, 0);
      end
      cycle(1, 1, 0, 0);
      quiet(4, 0);
      rcving = 1;
      pulse_nrst();
      quiet(3, 0);

      // random line activity
      cnt = 0; drop = 0;
      for (int i = 0; i < 2000; i++) begin
         de = 0;
         if (cnt == 0) begin
            de  = 1;
            cnt = $urandom_range(5, 11);
         end else begin
            cnt--;
         end
         if ($urandom_range(0, 399) == 0) cnt = 70;
         if (drop > 0) begin
            rc = 0;
            drop--;
         end else begin
            rc = 1;
            if ($urandom_range(0, 249) == 0) drop = $urandom_range(1, 4);
         end
         rs = ($urandom_range(0, 349) == 0);
         sk = ($urandom_range(0, 4) == 0);
         if ((SP == 0 || SP > 0) && $urandom_range(0, 799) == 0)
            pulse_nrst();
         else
            cycle(de, rc, rs, sk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
